// File: rtl/seg7_pkg.sv
// Shared definitions for the four-digit seven-segment scan controller.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN adds the leading-zero mask helper.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    OFF,
    BLANK,
    SHOW
  } state_t;

  // Active-low segment patterns {g,f,e,d,c,b,a}; entry 15 first, entry 0 last.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  localparam logic [6:0] SEG_OFF = 7'h7F;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Marks every digit at or below the highest nonzero nibble; digit 0 always counts.
  function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(input logic [4*NUM_DIGITS-1:0] v);
    logic [NUM_DIGITS-1:0] m;
    logic                  seen;
    m    = '0;
    seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      seen = seen | (|v[i*4 +: 4]);
      m[i] = seen;
    end
    m[0] = 1'b1;
    return m;
  endfunction
`endif

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Straight table lookup; every nibble value has a defined glyph.
  always_comb begin
    seg = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode display.
// Each digit slot is TICK_DIV cycles: BLANK_CYC dark cycles, then the digit.
// Display data is captured into shadow registers only at frame start.
// Build macro SEG7_LEADING_ZERO_BLANK_EN darkens digits above the top nonzero nibble.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int TICK_DIV  = 131579,
  parameter int BLANK_CYC = 1000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        scan_en,
  input  logic [15:0] digit_val,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done,
  output logic [1:0]  cur_digit
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [1:0]              idx;
  logic [15:0]             shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [NUM_DIGITS-1:0]   shadow_en;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0]   lz_mask;
`endif

  logic [3:0] cur_nib;
  logic [6:0] dec_seg;
  logic [6:0] show_seg;
  logic       digit_on;

  // Scan sequencer: slot timing, digit index and frame-boundary shadow capture.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state      <= OFF;
      cnt        <= '0;
      idx        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      shadow_en  <= '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      lz_mask    <= '0;
`endif
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!scan_en) begin
        state <= OFF;
        cnt   <= '0;
        idx   <= '0;
      end else begin
        case (state)
          OFF: begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= '0;
            shadow_val <= digit_val;
            shadow_dp  <= dp_in;
            shadow_en  <= digit_en;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            lz_mask    <= lead_zero_mask(digit_val);
`endif
          end
          BLANK: begin
            cnt <= cnt + 1'b1;
            if (cnt == BLANK_LAST) begin
              state <= SHOW;
            end
          end
          SHOW: begin
            if (cnt == SLOT_LAST) begin
              cnt   <= '0;
              idx   <= idx + 2'd1;
              state <= BLANK;
              if (idx == 2'd3) begin
                shadow_val <= digit_val;
                shadow_dp  <= dp_in;
                shadow_en  <= digit_en;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                lz_mask    <= lead_zero_mask(digit_val);
`endif
                frame_done <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= OFF;
            cnt   <= '0;
            idx   <= '0;
          end
        endcase
      end
    end
  end

  assign cur_nib   = shadow_val[{idx, 2'b00} +: 4];
  assign cur_digit = idx;

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  assign digit_on = shadow_en[idx] & (lz_mask[idx] | shadow_dp[idx]);
  assign show_seg = lz_mask[idx] ? dec_seg : SEG_OFF;
`else
  assign digit_on = shadow_en[idx];
  assign show_seg = dec_seg;
`endif

  // Pin drive: dark outside SHOW, otherwise the current digit's anode and glyph.
  always_comb begin
    an  = 4'hF;
    seg = SEG_OFF;
    dp  = 1'b1;
    if (state == SHOW) begin
      if (digit_on) begin
        an[idx] = 1'b0;
      end
      seg = show_seg;
      dp  = ~shadow_dp[idx];
    end
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexing scan controller for the 4-digit common-anode seven-segment display, clocked from the 100 MHz CLOCK.
- Uses an internal clock-enable counter, with no derived clock. The default per-digit rate is 760 Hz, giving a 190 Hz full frame.
- Sequences anodes with an inter-digit blanking window to suppress ghosting.
- Latches display data only at frame boundaries so digits never tear.
- Sits between application logic (score and state displays) and the board an/seg/dp pins.

Parameters:
TICK_DIV, 131579, CLOCK cycles per digit slot (blank + show); 100e6 / (4 × 131579) ≈ 190 Hz frame.
BLANK_CYC, 1000, cycles at the start of each slot with all anodes off; legal range 1 ≤ BLANK_CYC < TICK_DIV.

Ports:
CLOCK  input  1  system clock, 100 MHz
RESET  input  1  synchronous, active-high reset
scan_en  input  1  1 = scanning; 0 = display off
digit_val  input  16  four hex nibbles; [3:0] is digit 0 (rightmost)
dp_in  input  4  decimal point per digit, 1 = lit
digit_en  input  4  per-digit enable, 0 = digit stays dark in its slot
an  output  4  anodes, active-low
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low
frame_done  output  1  one-cycle pulse when a new frame begins
cur_digit  output  2  index of the current slot

Behaviour:
Clock and reset (already decided): one clock, CLOCK; reset RESET is synchronous and active-high.

Reset values (RESET=1 at an edge):
- state=OFF, cnt=0, idx=0, shadow registers=0.
- an=4'hF, seg=7'h7F, dp=1, frame_done=0, cur_digit=0.

States: OFF, BLANK, SHOW.
- OFF: outputs dark. If scan_en=1 → BLANK with cnt=0, idx=0, and shadow loaded from digit_val/dp_in/digit_en.
- BLANK: an=4'hF, seg=7'h7F, dp=1. cnt increments. When cnt==BLANK_CYC-1 → SHOW.
- SHOW: an[idx]=0 if shadow_en[idx], otherwise an=4'hF. seg=hex decode of shadow nibble idx. dp=~shadow_dp[idx]. cnt increments.
- SHOW exit: when cnt==TICK_DIV-1, set cnt=0, idx=idx+1 (mod 4), → BLANK.
- Frame wrap: if idx was 3 at SHOW exit, shadow reloads from the inputs and frame_done=1 for exactly that one cycle (the first BLANK cycle of digit 0).
- scan_en=0 in any state → OFF at the next edge, with cnt=0 and idx=0. A later re-enable restarts the frame at digit 0 and reloads shadow. That initial entry from OFF does not pulse frame_done.

Timing and outputs:
- Slot length is exactly TICK_DIV cycles; frame length is exactly 4×TICK_DIV cycles.
- an, seg, dp and cur_digit are combinational decodes of registered state/idx/shadow, so they change on the same edge the state changes.
- Input changes mid-frame have no effect until the next wrap.
- RESET mid-frame forces the reset values at the next edge, with no completion of the current slot.

Hex decode (active-low):
0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

Counter width: cnt width is $clog2(TICK_DIV).

Optional Feature:
SEG7_LEADING_ZERO_BLANK_EN
- Defined: at each shadow load, compute a lz_mask register. Digits above the highest nonzero nibble are forced dark, as if digit_en=0. Digit 0 is always eligible, so the value 0 shows as a single "0". dp_in still lights a blanked digit's decimal point only if that digit's digit_en=1.
- Undefined: all enabled digits are shown, including leading zeros. No lz_mask logic is present.

Decomposition:
- Package seg7_pkg holds:
  - NUM_DIGITS=4;
  - the state enum {OFF, BLANK, SHOW};
  - the 16-entry active-low segment constant table;
  - SEG_OFF=7'h7F.
- One sub-module, hex_to_seg7: combinational, 4-bit nibble → 7-bit active-low segments, from the package table.

Test Plan:
All scenarios use TICK_DIV=10, BLANK_CYC=2.
1. RESET, then scan_en=1, digit_val=16'h1234, digit_en=4'hF → dark for 2 cycles. Then an=1110 with seg=0011001 ('4') for 8 cycles. Then 2 blank cycles, then an=1101 with seg=0110000 ('3'). Frame repeats every 40 cycles; frame_done pulses once per 40.
2. Change digit_val to 16'hABCD during digit 1's slot → digits 2 and 3 still show '2' and '1'. After frame_done, digit 0 shows 0100001 ('d').
3. digit_en=4'b0101, dp_in=4'b0001 → only slots 0 and 2 light an. During slot 0, dp=0. Slots 1 and 3 stay an=4'hF for the full 10 cycles while cur_digit still advances.
4. Drop scan_en during SHOW of digit 2 → next edge an=4'hF, state OFF, cur_digit=0. Re-enable → digit 0 lit after 2 blank cycles, with no frame_done pulse.
5. Assert RESET for 1 cycle during BLANK of digit 3 → all outputs at reset values. Shadow is 0 and OFF persists until scan_en is seen.
6. With SEG7_LEADING_ZERO_BLANK_EN defined, digit_val=16'h0050, digit_en=4'hF → digits 3 and 2 dark. Digit 1 shows '5' and digit 0 shows '0'. With the macro undefined → all four digits lit.
